// File: rtl/axi4_stream_rx_fifo.sv
// AXI4-Stream slave receive FIFO: buffers beats with sideband, presents them FWFT
// to the NPU datapath, counts held packets and flags malformed byte qualifiers.
module axi4_stream_rx_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic [DATA_WIDTH/8-1:0] rx_keep,
    output logic                    rx_last,
    output logic [USER_WIDTH-1:0]   rx_user,
    output logic [ID_WIDTH-1:0]     rx_id,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    pkt_avail,
    output logic                    err_keep,
    input  logic                    err_clr
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
    logic                  mem_last [DEPTH];
    logic [USER_WIDTH-1:0] mem_user [DEPTH];
    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] pkt_cnt;
    logic          rst_q;
    logic          err_q;
    logic          push;
    logic          pop;
    logic          pkt_inc;
    logic          pkt_dec;
    logic          qual_err;

    // Ready is a pure function of registered state so the upstream master never
    // sees a combinational path from the consumer's rx_ready.
    assign s_axis_tready = !rst_q && (count != FULL);
    assign rx_valid      = (count != '0);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = rx_valid && rx_ready;
    assign pkt_inc       = push && s_axis_tlast;
    assign pkt_dec       = pop && rx_last;
    assign qual_err      = (s_axis_tstrb != s_axis_tkeep) ||
                           (!s_axis_tlast && (s_axis_tkeep != '1));

    assign rx_data    = rx_valid ? mem_data[rd_ptr] : '0;
    assign rx_keep    = rx_valid ? mem_keep[rd_ptr] : '0;
    assign rx_last    = rx_valid ? mem_last[rd_ptr] : 1'b0;
    assign rx_user    = rx_valid ? mem_user[rd_ptr] : '0;
    assign rx_id      = rx_valid ? mem_id[rd_ptr]   : '0;
    assign fifo_count = count;
    assign pkt_avail  = (pkt_cnt != '0);
    assign err_keep   = err_q;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data[wr_ptr] <= s_axis_tdata;
            mem_keep[wr_ptr] <= s_axis_tkeep;
            mem_last[wr_ptr] <= s_axis_tlast;
            mem_user[wr_ptr] <= s_axis_tuser;
            mem_id[wr_ptr]   <= s_axis_tid;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase

            // A new violation outranks a clear arriving in the same cycle.
            if (push && qual_err) err_q <= 1'b1;
            else if (err_clr)     err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_stream_rx_fifo.sv
// Scoreboard bench for axi4_stream_rx_fifo: a DEPTH=8 and a DEPTH=4 instance share stimulus.
module tb_axi4_stream_rx_fifo;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [3:0]   user;
        logic [3:0]   id;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] tdata;
    logic [15:0]  tstrb, tkeep;
    logic         tlast, tvalid, rx_ready, err_clr;
    logic [3:0]   tuser, tid;

    logic         tready8, rx_last8, rx_valid8, pkt8, err8;
    logic [127:0] rx_data8;
    logic [15:0]  rx_keep8;
    logic [3:0]   rx_user8, rx_id8, count8;

    logic         tready4, rx_last4, rx_valid4, pkt4, err4;
    logic [127:0] rx_data4;
    logic [15:0]  rx_keep4;
    logic [3:0]   rx_user4, rx_id4;
    logic [2:0]   count4;

    beat_t q[$];
    beat_t exp;
    bit    use4 = 1'b0;
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    axi4_stream_rx_fifo #(.DATA_WIDTH(128), .USER_WIDTH(4), .ID_WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tkeep(tkeep),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tid(tid),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready8),
        .rx_data(rx_data8), .rx_keep(rx_keep8), .rx_last(rx_last8),
        .rx_user(rx_user8), .rx_id(rx_id8), .rx_valid(rx_valid8), .rx_ready(rx_ready),
        .fifo_count(count8), .pkt_avail(pkt8), .err_keep(err8), .err_clr(err_clr)
    );

    axi4_stream_rx_fifo #(.DATA_WIDTH(128), .USER_WIDTH(4), .ID_WIDTH(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tkeep(tkeep),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tid(tid),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready4),
        .rx_data(rx_data4), .rx_keep(rx_keep4), .rx_last(rx_last4),
        .rx_user(rx_user4), .rx_id(rx_id4), .rx_valid(rx_valid4), .rx_ready(rx_ready),
        .fifo_count(count4), .pkt_avail(pkt4), .err_keep(err4), .err_clr(err_clr)
    );

    // Records accepted beats into the scoreboard, then advances one clock.
    task automatic step();
        if (!rst && tvalid && (use4 ? tready4 : tready8))
            q.push_back('{data: tdata, keep: tkeep, last: tlast, user: tuser, id: tid});
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [127:0] d, input logic [15:0] k, input logic [15:0] s,
                            input logic l, input logic [3:0] u, input logic [3:0] i);
        tdata = d; tkeep = k; tstrb = s; tlast = l; tuser = u; tid = i;
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        step();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tready8 !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", tready8); end
        checks++;
        if (rx_valid8 !== 1'b0 || count8 !== 4'd0 || pkt8 !== 1'b0 || err8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got valid=%b count=%0d pkt=%b err=%b exp 0/0/0/0",
                     rx_valid8, count8, pkt8, err8);
        end
        step();
        checks++;
        if (tready8 !== 1'b1) begin failures++; $display("FAIL idle_tready got=%b exp=1", tready8); end
    endtask

    task automatic test_single();
        use4 = 1'b0;
        set_beat({16{8'hA5}}, '1, '1, 1'b1, 4'd3, 4'd2);
        tvalid = 1'b1; rx_ready = 1'b0;
        step();
        tvalid = 1'b0;
        checks++;
        if (rx_valid8 !== 1'b1 || rx_data8 !== {16{8'hA5}} || rx_user8 !== 4'd3 || rx_id8 !== 4'd2) begin
            failures++;
            $display("FAIL single_head got valid=%b data=%h user=%0d id=%0d exp 1/a5..a5/3/2",
                     rx_valid8, rx_data8, rx_user8, rx_id8);
        end
        checks++;
        if (count8 !== 4'd1 || pkt8 !== 1'b1) begin
            failures++; $display("FAIL single_count got count=%0d pkt=%b exp 1/1", count8, pkt8);
        end
        rx_ready = 1'b1;
        if (rx_valid8) void'(q.pop_front());
        step();
        rx_ready = 1'b0;
        checks++;
        if (count8 !== 4'd0 || pkt8 !== 1'b0 || rx_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL single_pop got count=%0d pkt=%b valid=%b exp 0/0/0", count8, pkt8, rx_valid8);
        end
    endtask

    task automatic test_fill_depth4();
        logic [127:0] nxt;
        do_reset();
        step();
        use4 = 1'b1;
        nxt = '0;
        tvalid = 1'b1; rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(nxt, '1, '1, 1'b0, 4'd0, 4'd0);
            checks++;
            if (tready4 !== (i < 4)) begin
                failures++; $display("FAIL fill_tready cycle=%0d got=%b exp=%b", i, tready4, (i < 4));
            end
            if (tready4) nxt = nxt + 128'd1;
            step();
        end
        tvalid = 1'b0;
        checks++;
        if (count4 !== 3'd4 || tready4 !== 1'b0) begin
            failures++; $display("FAIL fill_full got count=%0d tready=%b exp 4/0", count4, tready4);
        end
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_valid4 !== 1'b1 || rx_data4 !== 128'(k)) begin
                failures++; $display("FAIL fill_order idx=%0d got=%h exp=%h", k, rx_data4, 128'(k));
            end
            if (rx_valid4 && q.size() != 0) void'(q.pop_front());
            step();
            if (k == 0) begin
                checks++;
                if (tready4 !== 1'b1) begin failures++; $display("FAIL fill_tready_return got=%b exp=1", tready4); end
            end
        end
        rx_ready = 1'b0;
        checks++;
        if (count4 !== 3'd0 || rx_valid4 !== 1'b0) begin
            failures++; $display("FAIL fill_drain got count=%0d valid=%b exp 0/0", count4, rx_valid4);
        end
        use4 = 1'b0;
        do_reset();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        rx_ready = 1'b0; tvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_beat({$urandom, $urandom, $urandom, $urandom}, '1, '1, 1'b0, 4'(i), 4'd1);
            step();
        end
        rx_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i >= 20) tvalid = 1'b0;
            set_beat({$urandom, $urandom, $urandom, $urandom}, '1, '1, 1'b0, 4'($urandom), 4'($urandom));
            if (i < 20) begin
                checks++;
                if (count8 !== 4'd2) begin failures++; $display("FAIL stream_count beat=%0d got=%0d exp=2", i, count8); end
            end
            checks++;
            if (!rx_valid8 || q.size() == 0) begin
                failures++; $display("FAIL stream_valid beat=%0d got=%b exp=1 sb=%0d", i, rx_valid8, q.size());
            end else begin
                exp = q.pop_front();
                if (rx_data8 !== exp.data || rx_user8 !== exp.user || rx_id8 !== exp.id) begin
                    failures++;
                    $display("FAIL stream_data beat=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", i,
                             rx_data8, rx_user8, rx_id8, exp.data, exp.user, exp.id);
                end
            end
            step();
        end
        rx_ready = 1'b0;
        checks++;
        if (count8 !== 4'd0) begin failures++; $display("FAIL stream_drain got=%0d exp=0", count8); end
    endtask

    task automatic test_packets();
        do_reset();
        step();
        tvalid = 1'b1; rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(128'(100 + i), '1, '1, 1'(i % 2), 4'd0, 4'd0);
            step();
        end
        tvalid = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pkt8 !== 1'b1) begin failures++; $display("FAIL pkt_avail_hold pop=%0d got=%b exp=1", i, pkt8); end
            if (q.size() != 0) begin
                exp = q.pop_front();
                checks++;
                if (rx_data8 !== exp.data || rx_last8 !== exp.last) begin
                    failures++;
                    $display("FAIL pkt_data pop=%0d got=%h/%b exp=%h/%b", i, rx_data8, rx_last8, exp.data, exp.last);
                end
            end
            step();
        end
        checks++;
        if (pkt8 !== 1'b0) begin failures++; $display("FAIL pkt_avail_clear got=%b exp=0", pkt8); end
        rx_ready = 1'b0; tvalid = 1'b1;
        set_beat(128'd7, '1, '1, 1'b1, 4'd0, 4'd0);
        step();
        rx_ready = 1'b1;
        set_beat(128'd8, '1, '1, 1'b1, 4'd0, 4'd0);
        if (q.size() != 0) void'(q.pop_front());
        step();
        tvalid = 1'b0; rx_ready = 1'b0;
        checks++;
        if (pkt8 !== 1'b1 || count8 !== 4'd1 || rx_data8 !== 128'd8) begin
            failures++;
            $display("FAIL pkt_simul got pkt=%b count=%0d data=%h exp 1/1/8", pkt8, count8, rx_data8);
        end
        rx_ready = 1'b1;
        if (q.size() != 0) void'(q.pop_front());
        step();
        rx_ready = 1'b0;
        checks++;
        if (pkt8 !== 1'b0) begin failures++; $display("FAIL pkt_simul_final got=%b exp=0", pkt8); end
    endtask

    task automatic test_err_keep();
        do_reset();
        step();
        tvalid = 1'b1;
        set_beat(128'h11, '1, '1, 1'b0, 4'd0, 4'd0);
        step();
        set_beat(128'h22, 16'h000F, 16'h000F, 1'b1, 4'd0, 4'd0);
        step();
        tvalid = 1'b0;
        checks++;
        if (err8 !== 1'b0) begin failures++; $display("FAIL err_clean got=%b exp=0", err8); end
        tvalid = 1'b1;
        set_beat(128'h33, 16'h00FF, 16'h00FF, 1'b0, 4'd0, 4'd0);
        step();
        tvalid = 1'b0;
        checks++;
        if (err8 !== 1'b1) begin failures++; $display("FAIL err_partial_keep got=%b exp=1", err8); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err8 !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err8); end
        err_clr = 1'b1; tvalid = 1'b1;
        set_beat(128'h44, '1, 16'hFFFE, 1'b1, 4'd0, 4'd0);
        step();
        err_clr = 1'b0; tvalid = 1'b0;
        checks++;
        if (err8 !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", err8); end
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (q.size() != 0) begin
                exp = q.pop_front();
                checks++;
                if (rx_valid8 !== 1'b1 || rx_data8 !== exp.data || rx_keep8 !== exp.keep) begin
                    failures++;
                    $display("FAIL err_stored idx=%0d got=%h/%h exp=%h/%h", i, rx_data8, rx_keep8, exp.data, exp.keep);
                end
            end
            step();
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        step();
        tvalid = 1'b1; rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat(128'(200 + i), '1, '1, 1'b0, 4'd0, 4'd0);
            step();
        end
        checks++;
        if (count8 !== 4'd5) begin failures++; $display("FAIL mid_count got=%0d exp=5", count8); end
        rst = 1'b1;
        step();
        rst = 1'b0; tvalid = 1'b0;
        q.delete();
        checks++;
        if (count8 !== 4'd0 || rx_valid8 !== 1'b0 || pkt8 !== 1'b0 || tready8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got count=%0d valid=%b pkt=%b tready=%b exp 0/0/0/0",
                     count8, rx_valid8, pkt8, tready8);
        end
        step();
        tvalid = 1'b1;
        set_beat(128'hDEAD_BEEF, '1, '1, 1'b1, 4'd5, 4'd6);
        step();
        set_beat(128'hFEED, '1, '1, 1'b1, 4'd0, 4'd0);
        step();
        tvalid = 1'b0;
        checks++;
        if (q.size() == 0 || rx_valid8 !== 1'b1) begin
            failures++; $display("FAIL mid_first_valid got=%b exp=1 sb=%0d", rx_valid8, q.size());
        end else begin
            exp = q.pop_front();
            if (rx_data8 !== exp.data || exp.data !== 128'hDEAD_BEEF || rx_user8 !== 4'd5) begin
                failures++;
                $display("FAIL mid_first_beat got=%h/%0d exp=%h/5", rx_data8, rx_user8, 128'hDEAD_BEEF);
            end
        end
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        set_beat('0, '0, '0, 1'b0, 4'd0, 4'd0);
        test_reset();
        test_single();
        test_fill_depth4();
        test_back_to_back();
        test_packets();
        test_err_keep();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
